// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback port arbiter and its scoreboard.
// The starvation guard is compiled in with the WB_STARVE_GUARD_EN macro.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned XLEN             = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned CNT_W            = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [XLEN-1:0] mask;
    mask     = {XLEN{1'b0}};
    mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination mask for long-latency ops: set on issue, cleared on result
// transfer, set wins on a collision, x0 never pending.
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [XLEN-1:0]       pending
);

  logic [XLEN-1:0] pending_r;
  logic [XLEN-1:0] pending_nxt_s;
  logic [XLEN-1:0] set_mask_s;
  logic [XLEN-1:0] clr_mask_s;

  // Next mask: clear first, then OR in the set so a same-bit set survives.
  always_comb begin
    set_mask_s = {XLEN{1'b0}};
    clr_mask_s = {XLEN{1'b0}};
    if (set_en) begin
      set_mask_s = rd_onehot(set_addr);
    end else begin
      set_mask_s = {XLEN{1'b0}};
    end
    if (clr_en) begin
      clr_mask_s = rd_onehot(clr_addr);
    end else begin
      clr_mask_s = {XLEN{1'b0}};
    end
    pending_nxt_s    = (pending_r & ~clr_mask_s) | set_mask_s;
    pending_nxt_s[0] = 1'b0;
  end

  // Mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {XLEN{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign pending = pending_r;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port shared by the in-order writeback slot (fixed priority)
// and the long-latency unit; optional starvation guard under WB_STARVE_GUARD_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wb_en,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]       i_wb_data,
  input  logic                  i_lu_valid,
  input  logic [REG_ADDR_W-1:0] i_lu_rd,
  input  logic [XLEN-1:0]       i_lu_data,
  output logic                  o_lu_ready,
  input  logic                  i_issue,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_waddr,
  output logic [XLEN-1:0]       o_rf_wdata,
  output logic [XLEN-1:0]       o_pending,
  output logic                  o_wb_stall
);

  logic                  slot_busy_s;
  logic                  lu_ready_s;
  logic                  transfer_s;
  logic                  issue_set_s;
  logic                  we_nxt_s;
  logic [REG_ADDR_W-1:0] waddr_nxt_s;
  logic [XLEN-1:0]       wdata_nxt_s;
  logic                  rf_we_r;
  logic [REG_ADDR_W-1:0] rf_waddr_r;
  logic [XLEN-1:0]       rf_wdata_r;

  assign slot_busy_s = i_wb_en && (i_wb_rd != {REG_ADDR_W{1'b0}});
  // Gated by reset so no handshake can complete while the block is held.
  assign lu_ready_s  = i_lu_valid && !slot_busy_s && i_rst;
  assign transfer_s  = i_lu_valid && lu_ready_s;
  assign issue_set_s = i_issue && (i_issue_rd != {REG_ADDR_W{1'b0}});

  // Winner select: pipeline slot first, then an LU transfer to a real register.
  always_comb begin
    we_nxt_s    = 1'b0;
    waddr_nxt_s = rf_waddr_r;
    wdata_nxt_s = rf_wdata_r;
    if (slot_busy_s) begin
      we_nxt_s    = 1'b1;
      waddr_nxt_s = i_wb_rd;
      wdata_nxt_s = i_wb_data;
    end else if (transfer_s && (i_lu_rd != {REG_ADDR_W{1'b0}})) begin
      we_nxt_s    = 1'b1;
      waddr_nxt_s = i_lu_rd;
      wdata_nxt_s = i_lu_data;
    end else begin
      we_nxt_s    = 1'b0;
      waddr_nxt_s = rf_waddr_r;
      wdata_nxt_s = rf_wdata_r;
    end
  end

  // Registered write port.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REG_ADDR_W{1'b0}};
      rf_wdata_r <= {XLEN{1'b0}};
    end else begin
      rf_we_r    <= we_nxt_s;
      rf_waddr_r <= waddr_nxt_s;
      rf_wdata_r <= wdata_nxt_s;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .set_en   (issue_set_s),
    .set_addr (i_issue_rd),
    .clr_en   (transfer_s),
    .clr_addr (i_lu_rd),
    .pending  (o_pending)
  );

`ifdef WB_STARVE_GUARD_EN
  arb_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             limit_hit_s;
  logic             stall_r;

  assign cnt_inc_s   = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : (cnt_r + 3'd1);
  assign limit_hit_s = ({29'd0, cnt_inc_s} >= STARVE_LIMIT);

  // Starvation FSM; stall is registered together with the FORCE entry.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      stall_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_lu_valid && !transfer_s) begin
            state_r <= ST_WAIT;
            cnt_r   <= 3'd1;
            stall_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            stall_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (transfer_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            stall_r <= 1'b0;
          end else if (limit_hit_s) begin
            state_r <= ST_FORCE;
            cnt_r   <= cnt_inc_s;
            stall_r <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
            cnt_r   <= cnt_inc_s;
            stall_r <= 1'b0;
          end
        end
        ST_FORCE: begin
          if (transfer_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            stall_r <= 1'b0;
          end else begin
            state_r <= ST_FORCE;
            cnt_r   <= cnt_inc_s;
            stall_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          stall_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_wb_stall = stall_r;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (STARVE_LIMIT == 32'd0);
  assign o_wb_stall   = 1'b0;
`endif

  assign o_lu_ready = lu_ready_s;
  assign o_rf_we    = rf_we_r;
  assign o_rf_waddr = rf_waddr_r;
  assign o_rf_wdata = rf_wdata_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Vector-table bench for wb_port_arbiter with an expected-result queue,
// plus directed starvation and mid-operation reset sequences.
module tb_wb_port_arbiter;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_wb_en;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        i_lu_valid;
  logic [4:0]  i_lu_rd;
  logic [31:0] i_lu_data;
  logic        o_lu_ready;
  logic        i_issue;
  logic [4:0]  i_issue_rd;
  logic        o_rf_we;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic [31:0] o_pending;
  logic        o_wb_stall;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  wb_port_arbiter dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wb_en    (i_wb_en),
    .i_wb_rd    (i_wb_rd),
    .i_wb_data  (i_wb_data),
    .i_lu_valid (i_lu_valid),
    .i_lu_rd    (i_lu_rd),
    .i_lu_data  (i_lu_data),
    .o_lu_ready (o_lu_ready),
    .i_issue    (i_issue),
    .i_issue_rd (i_issue_rd),
    .o_rf_we    (o_rf_we),
    .o_rf_waddr (o_rf_waddr),
    .o_rf_wdata (o_rf_wdata),
    .o_pending  (o_pending),
    .o_wb_stall (o_wb_stall)
  );

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        issue;
    logic [4:0]  issue_rd;
    logic        exp_ready;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_pending;
    logic        exp_stall;
    logic        chk_ad;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pending;
    logic        stall;
    logic        chk_ad;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[13];

  function automatic vec_t mk(
    input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
    input logic lu_valid, input logic [4:0] lu_rd, input logic [31:0] lu_data,
    input logic issue, input logic [4:0] issue_rd,
    input logic er, input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
    input logic [31:0] ep, input logic es, input logic ck);
    vec_t v;
    v.wb_en = wb_en;   v.wb_rd = wb_rd;     v.wb_data = wb_data;
    v.lu_valid = lu_valid; v.lu_rd = lu_rd; v.lu_data = lu_data;
    v.issue = issue;   v.issue_rd = issue_rd;
    v.exp_ready = er;  v.exp_we = ewe;      v.exp_waddr = ea;
    v.exp_wdata = ed;  v.exp_pending = ep;  v.exp_stall = es;
    v.chk_ad = ck;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic set_idle();
    i_wb_en = 1'b0; i_wb_rd = 5'd0; i_wb_data = 32'd0;
    i_lu_valid = 1'b0; i_lu_rd = 5'd0; i_lu_data = 32'd0;
    i_issue = 1'b0; i_issue_rd = 5'd0;
  endtask

  // One cycle: drive at negedge, check ready combinationally, queue the expected
  // registered result, then pop and compare just after the rising edge.
  task automatic drive(input vec_t v, input string tag);
    exp_t e;
    @(negedge i_clk);
    i_wb_en = v.wb_en; i_wb_rd = v.wb_rd; i_wb_data = v.wb_data;
    i_lu_valid = v.lu_valid; i_lu_rd = v.lu_rd; i_lu_data = v.lu_data;
    i_issue = v.issue; i_issue_rd = v.issue_rd;
    #1;
    chk({tag, " lu_ready"}, 32'(o_lu_ready), 32'(v.exp_ready));
    e.we = v.exp_we; e.waddr = v.exp_waddr; e.wdata = v.exp_wdata;
    e.pending = v.exp_pending; e.stall = v.exp_stall & GUARD;
    e.chk_ad = v.chk_ad; e.tag = tag;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, " rf_we"}, 32'(o_rf_we), 32'(e.we));
    if (e.chk_ad) begin
      chk({e.tag, " rf_waddr"}, 32'(o_rf_waddr), 32'(e.waddr));
      chk({e.tag, " rf_wdata"}, o_rf_wdata, e.wdata);
    end
    chk({e.tag, " pending"}, o_pending, e.pending);
    chk({e.tag, " wb_stall"}, 32'(o_wb_stall), 32'(e.stall));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rf_we"}, 32'(o_rf_we), 32'd0);
    chk({tag, " rf_waddr"}, 32'(o_rf_waddr), 32'd0);
    chk({tag, " rf_wdata"}, o_rf_wdata, 32'd0);
    chk({tag, " pending"}, o_pending, 32'd0);
    chk({tag, " wb_stall"}, 32'(o_wb_stall), 32'd0);
    chk({tag, " lu_ready"}, 32'(o_lu_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state: valid LU and a free slot must still see ready low.
    set_idle();
    i_rst = 1'b0;
    i_lu_valid = 1'b1; i_lu_rd = 5'd3;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    set_idle();
    i_rst = 1'b1;

    tbl[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    tbl[1]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    tbl[2]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7,
                 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80, 1'b0, 1'b1);
    tbl[3]  = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0,
                 1'b1, 1'b1, 5'd7, 32'h1234, 32'h0, 1'b0, 1'b1);
    tbl[4]  = mk(1'b1, 5'd0, 32'hFFFF0000, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd0,
                 1'b1, 1'b1, 5'd3, 32'h3333, 32'h0, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12,
                 1'b0, 1'b0, 5'd3, 32'h3333, 32'h1000, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0,
                 1'b0, 1'b0, 5'd3, 32'h3333, 32'h1000, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9,
                 1'b1, 1'b1, 5'd9, 32'h99, 32'h1200, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 5'd0, 32'h5, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0,
                 1'b1, 1'b1, 5'd12, 32'hC, 32'h200, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0,
                 1'b1, 1'b0, 5'd0, 32'h0, 32'h200, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 5'd20, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                 1'b0, 1'b1, 5'd20, 32'hA5A5A5A5, 32'h200, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0,
                 1'b0, 1'b1, 5'd1, 32'h11, 32'h200, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0,
                 1'b1, 1'b1, 5'd9, 32'h77, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i], $sformatf("vec%0d", i));
    end

    // Starvation: six busy cycles with the LU waiting, then the first free slot.
    drive(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4,
             1'b0, 1'b0, 5'd0, 32'd0, 32'h10, 1'b0, 1'b0), "starve_issue");
    for (int k = 1; k <= 6; k++) begin
      drive(mk(1'b1, 5'(10 + k), 32'(k), 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0,
               1'b0, 1'b1, 5'(10 + k), 32'(k), 32'h10, (k >= 4), 1'b1),
            $sformatf("starve_busy%0d", k));
    end
    drive(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0,
             1'b1, 1'b1, 5'd4, 32'h4444, 32'h0, 1'b0, 1'b1), "starve_grant");

    // Reset in the middle of WAIT with rd7 pending.
    drive(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7,
             1'b0, 1'b0, 5'd0, 32'd0, 32'h80, 1'b0, 1'b0), "mid_issue");
    for (int k = 1; k <= 3; k++) begin
      drive(mk(1'b1, 5'(20 + k), 32'hB0 + 32'(k), 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0,
               1'b0, 1'b1, 5'(20 + k), 32'hB0 + 32'(k), 32'h80, 1'b0, 1'b1),
            $sformatf("mid_busy%0d", k));
    end
    @(negedge i_clk);
    i_wb_en = 1'b0; i_lu_valid = 1'b1; i_lu_rd = 5'd7; i_lu_data = 32'h7777;
    #2;
    i_rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge i_clk);
    #1;
    chk_all_zero("held_rst");
    @(negedge i_clk);
    set_idle();
    i_rst = 1'b1;
    drive(mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
             1'b0, 1'b0, 5'd0, 32'd0, 32'h0, 1'b0, 1'b1), "post_rst_idle");
    for (int k = 1; k <= 4; k++) begin
      drive(mk(1'b1, 5'(24 + k), 32'hC0 + 32'(k), 1'b1, 5'd6, 32'h6666, 1'b0, 5'd0,
               1'b0, 1'b1, 5'(24 + k), 32'hC0 + 32'(k), 32'h0, (k == 4), 1'b1),
            $sformatf("restart_busy%0d", k));
    end
    drive(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6666, 1'b0, 5'd0,
             1'b1, 1'b1, 5'd6, 32'h6666, 32'h0, 1'b0, 1'b1), "restart_grant");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have the parameter STARVE_LIMIT, default 4, giving the maximum number of cycles a pending long-latency result waits before the pipeline is stalled.
REQ-002 The block SHALL have the port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the ports i_wb_en (input, 1), i_wb_rd (input, 5) and i_wb_data (input, 32): the in-order pipeline writeback slot, which cannot be backpressured.
REQ-005 The block SHALL have the ports i_lu_valid (input, 1), i_lu_rd (input, 5), i_lu_data (input, 32) and o_lu_ready (output, 1): the long-latency unit (mul/div) result handshake.
REQ-006 The block SHALL have the ports i_issue (input, 1) and i_issue_rd (input, 5): a long-latency op is dispatched targeting rd.
REQ-007 The block SHALL have the ports o_rf_we (output, 1), o_rf_waddr (output, 5) and o_rf_wdata (output, 32): the register-file write port, registered.
REQ-008 The block SHALL have the ports o_pending (output, 32), the scoreboard mask, and o_wb_stall (output, 1), which requests a pipeline freeze so the writeback slot goes empty.

Function
REQ-009 The pipeline slot SHALL be busy when i_wb_en=1 and i_wb_rd!=0.
- Writes with rd=0 SHALL be dropped and SHALL leave the slot free.
REQ-010 The pipeline slot SHALL have fixed priority: when busy, the next-cycle outputs SHALL be o_rf_we=1, o_rf_waddr=i_wb_rd, o_rf_wdata=i_wb_data.
REQ-011 o_lu_ready SHALL be combinational, equal to i_lu_valid AND slot not busy; a transfer is i_lu_valid&o_lu_ready.
REQ-012 On a transfer, the next-cycle write SHALL carry i_lu_rd/i_lu_data.
- If i_lu_rd=0, o_rf_we SHALL be 0 and the handshake SHALL still complete.
REQ-013 Write latency SHALL be exactly 1 cycle from the winning input to o_rf_*.
- In a cycle with no winner, o_rf_we SHALL be 0 and o_rf_waddr/o_rf_wdata SHALL hold their previous values.
REQ-014 The scoreboard SHALL behave as follows:
- i_issue with i_issue_rd!=0 sets o_pending[rd] next cycle.
- A transfer clears o_pending[i_lu_rd].
- Bit 0 is always 0.
REQ-015 On a simultaneous set and clear of the same bit, set SHALL win.
REQ-016 The FSM SHALL have the states IDLE, WAIT and FORCE, with a 3-bit wait counter (saturating):
- IDLE->WAIT when i_lu_valid=1 and no transfer; counter=1.
- WAIT: the counter increments per cycle without transfer; ->FORCE when counter reaches STARVE_LIMIT; ->IDLE on transfer.
- FORCE: o_wb_stall=1 (registered, asserted the cycle after entry); ->IDLE on transfer, o_wb_stall deasserts the cycle after the transfer.
- A transfer in IDLE stays in IDLE.
REQ-017 i_lu_valid SHALL NOT drop before its transfer, and i_issue_rd SHALL NOT target a bit already pending; both are bench assertions, with no recovery logic.
REQ-018 A pipeline write to a pending rd SHALL be written normally; decode prevents this using o_pending.

Reset
REQ-019 While i_rst=0, the block SHALL hold o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_pending=0, o_wb_stall=0, FSM=IDLE and counter=0; o_lu_ready SHALL be 0 regardless of inputs.
REQ-020 A reset mid-operation SHALL discard in-flight results and scoreboard contents, with no write after release until a new winner.

Configuration
REQ-021 The macro WB_STARVE_GUARD_EN SHALL control the starvation guard:
- Defined: the FSM and counter per REQ-016.
- Undefined: the FSM and counter are removed, o_wb_stall is tied to 0, and the long-latency unit is served only in free slots.

Structure
REQ-022 The shared package SHALL hold the FSM state enum, REG_ADDR_W=5, XLEN=32 and the default STARVE_LIMIT.
REQ-023 The scoreboard SHALL be one sub-module, wb_scoreboard, with set/clear ports and the 32-bit mask.
- Arbitration, FSM and output registers SHALL stay in wb_port_arbiter.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Pipeline only: i_wb_en=1, rd=5, data=0xDEADBEEF -> next cycle o_rf_we=1, waddr=5, wdata=0xDEADBEEF; o_lu_ready=0 during the busy cycle.
- Free-slot grant: i_issue rd=7, then i_lu_valid rd=7 data=0x1234 with the slot free -> o_lu_ready=1 the same cycle; next cycle write rd7=0x1234 and o_pending[7] 1->0.
- Starvation: slot busy for 6 cycles while i_lu_valid=1, STARVE_LIMIT=4 -> o_wb_stall=1 from cycle 5; the first free slot grants the LU; o_wb_stall=0 the following cycle. Without WB_STARVE_GUARD_EN, o_wb_stall stays 0.
- x0 handling: i_wb_en=1 rd=0 together with i_lu_valid rd=3 -> LU granted the same cycle; i_issue rd=0 -> o_pending unchanged.
- Set/clear collision: transfer rd=9 while i_issue rd=9 in the same cycle -> o_pending[9]=1 afterwards.
- Reset mid-WAIT: assert i_rst=0 asynchronously with counter=3 and o_pending=0x80 -> all outputs 0 immediately; after release the FSM restarts from IDLE.
